// File: rtl/hazwell_mem_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package hazwell_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/arb_sel2.sv
// Two-way combinational winner select. Round-robin when MEM_PORT_ARB_RR_EN is
// defined, otherwise fixed priority with the data port winning.
module arb_sel2
    import hazwell_mem_pkg::*;
(
`ifdef MEM_PORT_ARB_RR_EN
    input  logic last_grant,
`endif
    input  logic req0,
    input  logic req1,
    output logic grant
);

    always_comb begin
        grant = PORT_FETCH;
        if (req0 && req1) begin
`ifdef MEM_PORT_ARB_RR_EN
            grant = ~last_grant;
`else
            grant = PORT_DATA;
`endif
        end else if (req1) begin
            grant = PORT_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the CPU memory port between fetch (port 0) and data (port 1) with an
// IDLE/ACCESS/DONE handshake. Arbitration mode selected by MEM_PORT_ARB_RR_EN.
module mem_port_arbiter
    import hazwell_mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          iClk,
    input  logic          nRst,
    input  logic          iReq0,
    input  logic          iReq1,
    input  logic          iWe0,
    input  logic          iWe1,
    input  logic [AW-1:0] iAddr0,
    input  logic [AW-1:0] iAddr1,
    input  logic [DW-1:0] iWData0,
    input  logic [DW-1:0] iWData1,
    output logic          oAck0,
    output logic          oAck1,
    output logic [DW-1:0] oRData,
    output logic [AW-1:0] oMemAddr,
    output logic [DW-1:0] oMemData,
    input  logic [DW-1:0] iMemData,
    output logic          oMemRead,
    output logic          oMemWrite,
    input  logic          iMemReady,
    output logic          oBusy
);

    state_t state_reg;
    state_t state_next;
    logic   start;
    logic   finish;
    logic   win;
    logic   win_we;
    logic   owner_reg;
    logic   we_reg;

`ifdef MEM_PORT_ARB_RR_EN
    logic   last_grant_reg;

    // Reset as if fetch won last, so the first tie goes to the data port.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            last_grant_reg <= PORT_FETCH;
        end else if (start) begin
            last_grant_reg <= win;
        end
    end
`endif

    arb_sel2 u_sel (
`ifdef MEM_PORT_ARB_RR_EN
        .last_grant (last_grant_reg),
`endif
        .req0       (iReq0),
        .req1       (iReq1),
        .grant      (win)
    );

    assign win_we = win ? iWe1 : iWe0;
    assign oBusy  = (state_reg != IDLE);

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (iReq0 || iReq1) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (iMemReady) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory address/data double as the request latches, so they naturally
    // hold their last values outside ACCESS.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            owner_reg <= PORT_FETCH;
            we_reg    <= 1'b0;
            oMemAddr  <= '0;
            oMemData  <= '0;
            oMemRead  <= 1'b0;
            oMemWrite <= 1'b0;
            oRData    <= '0;
            oAck0     <= 1'b0;
            oAck1     <= 1'b0;
        end else begin
            oAck0 <= 1'b0;
            oAck1 <= 1'b0;
            if (start) begin
                owner_reg <= win;
                we_reg    <= win_we;
                oMemAddr  <= win ? iAddr1 : iAddr0;
                oMemData  <= win ? iWData1 : iWData0;
                oMemRead  <= ~win_we;
                oMemWrite <= win_we;
            end
            if (finish) begin
                oMemRead  <= 1'b0;
                oMemWrite <= 1'b0;
                if (!we_reg) begin
                    oRData <= iMemData;
                end
                oAck0 <= (owner_reg == PORT_FETCH);
                oAck1 <= (owner_reg == PORT_DATA);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of grants, completions and idle slots.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEM_PORT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          iClk = 1'b0;
    logic          nRst;
    logic          iReq0, iReq1, iWe0, iWe1;
    logic [AW-1:0] iAddr0, iAddr1;
    logic [DW-1:0] iWData0, iWData1;
    logic          oAck0, oAck1;
    logic [DW-1:0] oRData;
    logic [AW-1:0] oMemAddr;
    logic [DW-1:0] oMemData;
    logic [DW-1:0] iMemData;
    logic          oMemRead, oMemWrite;
    logic          iMemReady;
    logic          oBusy;

    always #5 iClk = ~iClk;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .iClk      (iClk),
        .nRst      (nRst),
        .iReq0     (iReq0),
        .iReq1     (iReq1),
        .iWe0      (iWe0),
        .iWe1      (iWe1),
        .iAddr0    (iAddr0),
        .iAddr1    (iAddr1),
        .iWData0   (iWData0),
        .iWData1   (iWData1),
        .oAck0     (oAck0),
        .oAck1     (oAck1),
        .oRData    (oRData),
        .oMemAddr  (oMemAddr),
        .oMemData  (oMemData),
        .iMemData  (iMemData),
        .oMemRead  (oMemRead),
        .oMemWrite (oMemWrite),
        .iMemReady (iMemReady),
        .oBusy     (oBusy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction-level model: one access in flight at most; after a
    // completion edge the next grant may happen no earlier than two edges on.
    bit          m_active, m_owner, m_we, m_last;
    int          m_free;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    bit          exp_ack0, exp_ack1, exp_rd, exp_wr, exp_busy;
    bit          keep0, keep1;
    int          ack_port[$];
    int          ack_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_owner   = 1'b0;
        m_we      = 1'b0;
        m_last    = 1'b0;
        m_free    = 0;
        exp_rdata = '0;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_ack0  = 1'b0;
        exp_ack1  = 1'b0;
        exp_rd    = 1'b0;
        exp_wr    = 1'b0;
        exp_busy  = 1'b0;
    endtask

    task automatic model_edge();
        bit w;
        exp_ack0 = 1'b0;
        exp_ack1 = 1'b0;
        if (m_active) begin
            if (iMemReady) begin
                m_active = 1'b0;
                if (m_owner) exp_ack1 = 1'b1;
                else         exp_ack0 = 1'b1;
                if (!m_we) exp_rdata = iMemData;
                m_free = cyc + 2;
            end
        end else if (cyc >= m_free && (iReq0 || iReq1)) begin
            if (iReq0 && iReq1) w = RR ? ~m_last : 1'b1;
            else                w = iReq1;
            m_last    = w;
            m_owner   = w;
            m_active  = 1'b1;
            m_we      = w ? iWe1 : iWe0;
            exp_addr  = w ? iAddr1 : iAddr0;
            exp_wdata = w ? iWData1 : iWData0;
        end
        exp_rd   = m_active && !m_we;
        exp_wr   = m_active && m_we;
        exp_busy = m_active || (cyc + 1 < m_free);
    endtask

    task automatic compare_all();
        check("ack0",    oAck0,     exp_ack0);
        check("ack1",    oAck1,     exp_ack1);
        check("rdata",   oRData,    exp_rdata);
        check("memaddr", oMemAddr,  exp_addr);
        check("memdata", oMemData,  exp_wdata);
        check("memread", oMemRead,  exp_rd);
        check("memwrite",oMemWrite, exp_wr);
        check("busy",    oBusy,     exp_busy);
    endtask

    task automatic new_req(input int p);
        if (p == 0) begin
            iReq0 = 1'b1; iWe0 = 1'($urandom_range(1));
            iAddr0 = $urandom; iWData0 = $urandom;
        end else begin
            iReq1 = 1'b1; iWe1 = 1'($urandom_range(1));
            iAddr1 = $urandom; iWData1 = $urandom;
        end
    endtask

    task automatic update_reqs(input bit rnd);
        if (exp_ack0) begin
            if (rnd) begin
                if ($urandom_range(1) == 1) new_req(0);
                else iReq0 = 1'b0;
            end else if (!keep0) iReq0 = 1'b0;
        end else if (rnd && !iReq0 && $urandom_range(2) == 0) new_req(0);
        if (exp_ack1) begin
            if (rnd) begin
                if ($urandom_range(1) == 1) new_req(1);
                else iReq1 = 1'b0;
            end else if (!keep1) iReq1 = 1'b0;
        end else if (rnd && !iReq1 && $urandom_range(2) == 0) new_req(1);
        if (rnd) begin
            iMemReady = ($urandom_range(3) != 0);
            iMemData  = $urandom;
        end
    endtask

    task automatic step(input bit rnd);
        @(posedge iClk);
        cyc++;
        model_edge();
        #1;
        compare_all();
        if (oAck0 === 1'b1 || oAck1 === 1'b1) begin
            ack_port.push_back(oAck1 ? 1 : 0);
            ack_cyc.push_back(cyc);
            $display("txn cycle %0d port %0d rdata %h", cyc, oAck1 ? 1 : 0, oRData);
        end
        update_reqs(rnd);
    endtask

    task automatic check_acks(input string tag, input int n, input int p_first, input bit alt);
        int exp_p;
        check({tag, "_count"}, 32'(ack_port.size() >= n), 32'd1);
        for (int i = 0; i < n && i < ack_port.size(); i++) begin
            exp_p = (alt && (i % 2 == 1)) ? 1 - p_first : p_first;
            check({tag, "_port"}, ack_port[i], exp_p);
            if (i > 0) check({tag, "_gap"}, ack_cyc[i] - ack_cyc[i-1], 32'd3);
        end
    endtask

    initial begin
        nRst = 1'b0;
        iReq0 = 0; iReq1 = 0; iWe0 = 0; iWe1 = 0;
        iAddr0 = '0; iAddr1 = '0; iWData0 = '0; iWData1 = '0;
        iMemData = '0; iMemReady = 1'b0;
        keep0 = 0; keep1 = 0;
        model_reset();
        repeat (2) @(posedge iClk);
        #1;
        compare_all();
        nRst = 1'b1;

        // Single fetch read, zero wait.
        iReq0 = 1; iWe0 = 0; iAddr0 = 32'h0; iMemData = 32'h04001017; iMemReady = 1;
        repeat (5) step(0);
        check("fetch_rdata", oRData, 32'h04001017);

        // Data write with two wait cycles.
        iReq1 = 1; iWe1 = 1; iAddr1 = 32'h1000; iWData1 = 32'h10; iMemReady = 0;
        step(0); step(0); step(0);
        iMemReady = 1;
        repeat (4) step(0);

        // Reset in the middle of a stalled read.
        iReq0 = 1; iWe0 = 0; iAddr0 = 32'h2000; iMemReady = 0;
        step(0); step(0);
        #2 nRst = 1'b0;
        #1;
        check("rst_read",  oMemRead,  1'b0);
        check("rst_write", oMemWrite, 1'b0);
        check("rst_busy",  oBusy,     1'b0);
        check("rst_ack0",  oAck0,     1'b0);
        check("rst_rdata", oRData,    32'h0);
        model_reset();
        iReq0 = 0;
        @(posedge iClk);
        #1 nRst = 1'b1;
        compare_all();

        // Continuous tie: first goes to port 1, then per mode.
        ack_port.delete(); ack_cyc.delete();
        keep0 = 1; keep1 = 1; iMemReady = 1;
        iReq0 = 1; iWe0 = 0; iAddr0 = 32'h40;
        iReq1 = 1; iWe1 = 0; iAddr1 = 32'h80;
        repeat (13) step(0);
        check_acks("tie", 4, 1, RR);
        keep0 = 0; keep1 = 0;
        repeat (10) step(0);

        // Fetch re-requests through its ack cycle.
        ack_port.delete(); ack_cyc.delete();
        keep0 = 1; iReq0 = 1; iAddr0 = 32'h100;
        repeat (10) step(0);
        check_acks("rereq", 3, 0, 1'b0);
        keep0 = 0;
        repeat (5) step(0);

        // Random traffic.
        repeat (3000) step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
